// File: rtl/muldiv_if.sv
// Operand/control/result bundle between the CPU datapath and the multiply/divide unit.
// The master drives requests and MTHI/MTLO writes; the slave returns status and HI/LO.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, we_hi, we_lo, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, we_hi, we_lo, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with architectural HI/LO; start-to-done latency 33 cycles.
// No backpressure: start and MTHI/MTLO writes are only honoured in IDLE, otherwise dropped; busy stalls the core.
module muldiv_unit (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        b_zero;
  logic [31:0] a_orig;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign sgn   = ~bus.op[0];
  assign a_mag = (sgn && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign b_mag = (sgn && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // Multiply: multiplier sits in acc[31:0] and is consumed LSB-first while the product grows from the top.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

  // Divide: acc[31:0] holds dividend bits shifting out and quotient bits shifting in.
  assign div_shift = {rem, acc[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem   = div_shift[31:0] - opnd;

  assign prod_fix = neg_res ? (64'd0 - acc) : acc;
  assign quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem_fix  = neg_rem ? (32'd0 - rem) : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_orig  <= 32'd0;
      opnd    <= 32'd0;
      acc     <= 64'd0;
      rem     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div  <= bus.op[1];
            neg_res <= sgn & (bus.a[31] ^ bus.b[31]);
            neg_rem <= sgn & bus.a[31];
            b_zero  <= (bus.b == 32'd0);
            a_orig  <= bus.a;
            rem     <= 32'd0;
            cnt     <= 5'd31;
            busy_q  <= 1'b1;
            state   <= CALC;
            if (bus.op[1]) begin
              opnd <= b_mag;
              acc  <= {32'd0, a_mag};
            end else begin
              opnd <= a_mag;
              acc  <= {32'd0, b_mag};
            end
          end else begin
            if (bus.we_hi) hi_q <= bus.wdata;
            if (bus.we_lo) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          if (is_div) begin
            if (div_ge) begin
              rem <= div_rem;
              acc <= {acc[63:32], acc[30:0], 1'b1};
            end else begin
              rem <= div_shift[31:0];
              acc <= {acc[63:32], acc[30:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          if (cnt == 5'd0) state <= FIX;
          else             cnt   <= cnt - 5'd1;
        end
        FIX: begin
          if (is_div) begin
            if (b_zero) begin
              lo_q <= 32'hFFFF_FFFF;
              hi_q <= a_orig;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
